// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
//
// Shared definitions for the parametrised serial-pattern detector.
//   - Parameter limits (MAX_SEQ_LEN, MAX_CNT_W).
//   - pattern_t: a pattern zero-extended to the maximum supported length.
//   - det_phase_t: coarse FSM phase (idle / partial match / detect).
//   - Constant functions used at elaboration to build the transition table:
//       seq_next()   : next state from a non-DETECT state for one input bit
//       seq_border() : longest proper border of the pattern
//
// Pattern bit ordering: PATTERN[len-1] is the first bit received and
// PATTERN[0] the last, so "prefix position i" lives at bit (len-1-i).
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int MAX_SEQ_LEN = 16;
    localparam int MAX_CNT_W   = 32;

    typedef logic [MAX_SEQ_LEN-1:0] pattern_t;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,  // nothing matched
        PH_PARTIAL = 2'd1,  // part of the pattern matched
        PH_DETECT  = 2'd2   // full pattern matched
    } det_phase_t;

    // Bit at prefix position idx (0 = first bit received).
    function automatic logic pat_bit(pattern_t pattern, int len, int idx);
        pattern_t t;
        t = pattern >> (len - 1 - idx);
        return t[0];
    endfunction

    // Next state from 'state' (must be < len) after receiving bit b.
    // On a mismatch this is the KMP fall-back: the longest prefix of the
    // pattern that is a proper suffix of (matched prefix followed by b).
    function automatic int seq_next(pattern_t pattern, int len, int state, logic b);
        int   res;
        logic found;
        logic ok;
        logic c;
        int   j;
        res   = 0;
        found = 1'b0;
        if (b == pat_bit(pattern, len, state)) begin
            res   = state + 1;
            found = 1'b1;
        end
        // Candidate string has length state+1; try suffixes of length
        // state down to 1, keeping the first (longest) that is a prefix.
        for (int k = state; k > 0; k--) begin
            if (!found) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    j = state + 1 - k + i;
                    c = (j == state) ? b : pat_bit(pattern, len, j);
                    if (c != pat_bit(pattern, len, i)) ok = 1'b0;
                end
                if (ok) begin
                    res   = k;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Longest proper border: largest k < len with prefix(k) == suffix(k).
    function automatic int seq_border(pattern_t pattern, int len);
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < len; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (pat_bit(pattern, len, i) != pat_bit(pattern, len, len - k + i)) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with synchronous reset and synchronous clear.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (count=0, sat=0)
//   clr   : synchronous clear, same effect as rst; wins over inc
//   inc   : add one on this edge unless already saturated
//   count : current count, W bits
//   sat   : 1 once count has reached 2^W-1; set on the same edge
// -----------------------------------------------------------------------------
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    if ((W < 1) || (W > MAX_CNT_W)) begin : g_bad_width
        $error("sat_counter: W=%0d outside 1..%0d", W, MAX_CNT_W);
    end

    logic [W-1:0] count_inc;

    assign count_inc = count + W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && !sat) begin
            count <= count_inc;
            // All-ones after the increment means the maximum was just reached.
            sat   <= &count_inc;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised Moore serial-pattern detector with a saturating match counter.
//
// Parameters
//   SEQ_LEN : pattern length, 2..16
//   PATTERN : pattern bits, PATTERN[SEQ_LEN-1] received first
//   OVERLAP : 0 = non-overlapping, 1 = overlapping detection
//   CNT_W   : match counter width, 1..32
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, overrides everything
//   en        : sample enable; x consumed only when en=1
//   x         : serial data bit
//   cnt_clr   : synchronous clear of match_cnt / cnt_sat (honoured when en=0)
//   y         : Moore detect flag, high while the FSM is in DETECT
//   match_cnt : number of DETECT entries since reset/clear, saturating
//   cnt_sat   : high once match_cnt reached 2^CNT_W-1
//
// The state is the number of pattern bits matched (0..SEQ_LEN); SEQ_LEN is
// DETECT. All transitions come from a constant table built at elaboration,
// so there is no runtime pattern-matching logic.
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b0100,
    parameter bit                 OVERLAP = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if ((SEQ_LEN < 2) || (SEQ_LEN > MAX_SEQ_LEN)) begin : g_bad_len
        $error("seq_detector_param: SEQ_LEN=%0d outside 2..%0d", SEQ_LEN, MAX_SEQ_LEN);
    end
    if ((CNT_W < 1) || (CNT_W > MAX_CNT_W)) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W=%0d outside 1..%0d", CNT_W, MAX_CNT_W);
    end

    localparam int              SW      = $clog2(SEQ_LEN + 1);
    localparam int              NSTATES = 1 << SW;
    localparam pattern_t        PAT     = pattern_t'(PATTERN);
    localparam int              BORDER  = seq_border(PAT, SEQ_LEN);
    localparam logic [SW-1:0]   DET     = SW'(SEQ_LEN);

    logic [SW-1:0] s;
    logic [SW-1:0] next_s;
    det_phase_t    phase;
    det_phase_t    next_phase;
    logic          enter_det;

    // Next-state table, one entry per encodable state and input bit.
    // The table covers every encoding of s so an unreachable value
    // (above SEQ_LEN) still has a defined exit, treated like state 0.
    logic [SW-1:0] tbl0 [NSTATES];
    logic [SW-1:0] tbl1 [NSTATES];

    for (genvar g = 0; g < NSTATES; g++) begin : g_tbl
        // DETECT continues from the border when overlapping, else from 0.
        localparam int FROM = (g < SEQ_LEN) ? g :
                              (((g == SEQ_LEN) && OVERLAP) ? BORDER : 0);
        localparam logic [SW-1:0] N0 = SW'(seq_next(PAT, SEQ_LEN, FROM, 1'b0));
        localparam logic [SW-1:0] N1 = SW'(seq_next(PAT, SEQ_LEN, FROM, 1'b1));
        assign tbl0[g] = N0;
        assign tbl1[g] = N1;
    end

    always_comb begin
        next_s     = x ? tbl1[s] : tbl0[s];
        next_phase = PH_PARTIAL;
        if (next_s == DET) begin
            next_phase = PH_DETECT;
        end else if (next_s == '0) begin
            next_phase = PH_IDLE;
        end
    end

    // Any enabled edge landing in DETECT counts, including DETECT->DETECT.
    assign enter_det = en && (next_s == DET);

    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            phase <= PH_IDLE;
        end else if (en) begin
            s     <= next_s;
            phase <= next_phase;
        end
    end

    // Decode of a register only: no combinational path from x to y.
    assign y = (phase == PH_DETECT);

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (enter_det),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Five detector configurations share one input stream:
//   0: 0100 non-overlap, CNT_W=8     1: 0100 overlap, CNT_W=8
//   2: 1111 overlap, CNT_W=8         3: 1111 non-overlap, CNT_W=8
//   4: 11 overlap, CNT_W=2
// A sliding-window reference model predicts y/match_cnt/cnt_sat per cycle.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    localparam int N = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, x, cnt_clr;

    logic       y0, y1, y2, y3, y4;
    logic [7:0] c0, c1, c2, c3;
    logic [1:0] c4;
    logic       s0, s1, s2, s3, s4;

    seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b0100), .OVERLAP(1'b0), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr),
        .y(y0), .match_cnt(c0), .cnt_sat(s0));
    seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b0100), .OVERLAP(1'b1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr),
        .y(y1), .match_cnt(c1), .cnt_sat(s1));
    seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr),
        .y(y2), .match_cnt(c2), .cnt_sat(s2));
    seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(8)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr),
        .y(y3), .match_cnt(c3), .cnt_sat(s3));
    seq_detector_param #(.SEQ_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cnt_clr(cnt_clr),
        .y(y4), .match_cnt(c4), .cnt_sat(s4));

    // ---------------- reference model ----------------
    int          m_len [N] = '{4, 4, 4, 4, 2};
    logic [15:0] m_pat [N] = '{16'h0004, 16'h0004, 16'h000F, 16'h000F, 16'h0003};
    bit          m_ov  [N] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int          m_cw  [N] = '{8, 8, 8, 8, 2};

    logic [15:0] win   [N];   // most recent bits, newest in bit 0
    int          since [N];   // bits usable for the next match
    logic        ey    [N];
    int          ecnt  [N];
    logic        esat  [N];

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int stepn  = 0;

    function automatic logic [9:0] obs(int i);
        logic [9:0] o;
        case (i)
            0:       o = {s0, c0, y0};
            1:       o = {s1, c1, y1};
            2:       o = {s2, c2, y2};
            3:       o = {s3, c3, y3};
            default: o = {s4, 6'b0, c4, y4};
        endcase
        return o;
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One clock edge of the specified behaviour for every configuration.
    task automatic model_update(logic r, logic e, logic b, logic c);
        logic match;
        int   mx;
        for (int i = 0; i < N; i++) begin
            mx = (1 << m_cw[i]) - 1;
            if (r) begin
                win[i] = '0; since[i] = 0; ey[i] = 1'b0; ecnt[i] = 0; esat[i] = 1'b0;
            end else begin
                match = 1'b0;
                if (e) begin
                    win[i]   = {win[i][14:0], b};
                    since[i] = (since[i] < 16) ? since[i] + 1 : 16;
                    match    = (since[i] >= m_len[i]) &&
                               ((win[i] & 16'((1 << m_len[i]) - 1)) == m_pat[i]);
                    ey[i]    = match;
                    // Non-overlapping: bits of this match cannot be reused.
                    if (match && !m_ov[i]) since[i] = 0;
                end
                if (c) begin
                    ecnt[i] = 0;
                    esat[i] = 1'b0;
                end else if (match && (ecnt[i] < mx)) begin
                    ecnt[i] = ecnt[i] + 1;
                    esat[i] = (ecnt[i] == mx);
                end
            end
            exp_q.push_back({esat[i], 8'(ecnt[i]), ey[i]});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(logic r, logic e, logic b, logic c);
        rst = r; en = e; x = b; cnt_clr = c;
        @(posedge clk);
        model_update(r, e, b, c);
        @(negedge clk);
        stepn++;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("step%0d_inst%0d", stepn, i), 32'(obs(i)), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic feed(logic [15:0] bits, int n);
        logic [15:0] t;
        for (int k = 0; k < n; k++) begin
            t = bits >> (n - 1 - k);
            cyc(1'b0, 1'b1, t[0], 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bias;
        rst = 1'b1; en = 1'b0; x = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_y0", 32'(y0), 32'd0);
        chk("reset_cnt0", 32'(c0), 32'd0);

        // 0100 then 100: non-overlap detects once, overlap twice
        feed(16'b0100, 4);
        chk("t1_y0_after_bit4", 32'(y0), 32'd1);
        chk("t2_y1_after_bit4", 32'(y1), 32'd1);
        feed(16'b100, 3);
        chk("t1_y0_after_bit7", 32'(y0), 32'd0);
        chk("t1_cnt0", 32'(c0), 32'd1);
        chk("t2_y1_after_bit7", 32'(y1), 32'd1);
        chk("t2_cnt1", 32'(c1), 32'd2);

        // Eight 1s on 1111
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        feed(16'hFF, 8);
        chk("t3_ov_cnt", 32'(c2), 32'd5);
        chk("t3_ov_y", 32'(y2), 32'd1);
        chk("t3_nov_cnt", 32'(c3), 32'd2);
        chk("t3_nov_y", 32'(y3), 32'd1);

        // Saturation on 2-bit counter, then clear
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        feed(16'b11, 2);
        chk("t5_cnt_1", 32'(c4), 32'd1);
        feed(16'b11, 2);
        chk("t5_cnt_3", 32'(c4), 32'd3);
        chk("t5_sat", 32'(s4), 32'd1);
        feed(16'b11, 2);
        chk("t5_cnt_hold", 32'(c4), 32'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_clr_cnt", 32'(c4), 32'd0);
        chk("t5_clr_sat", 32'(s4), 32'd0);

        // Enable gap inside a partial match
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        feed(16'b010, 3);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 1'(k), 1'b0);
            chk($sformatf("t4_gap_y0_%0d", k), 32'(y0), 32'd0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_resume_y0", 32'(y0), 32'd1);
        chk("t4_resume_cnt0", 32'(c0), 32'd1);

        // Reset while in DETECT, then clear coincident with a detect entry
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_rst_y0", 32'(y0), 32'd0);
        chk("t6_rst_cnt0", 32'(c0), 32'd0);
        feed(16'b010, 3);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t6_clr_y0", 32'(y0), 32'd1);
        chk("t6_clr_cnt0", 32'(c0), 32'd0);

        // Randomised stream, bias varied so runs of 1s appear
        bias = 50;
        for (int n = 0; n < 600; n++) begin
            if ((n % 50) == 0) bias = $urandom_range(20, 95);
            cyc(1'($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 99) < bias),
                1'($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore serial-pattern detector. It is the generalised successor to the fixed 4-bit, non-overlapping sequence detectors in the digital-logic library. Pattern, pattern length and overlap mode are set at elaboration. Adds a sample-enable, a saturating match counter with synchronous clear, and a saturation flag. Used as a reusable serial-stream pattern spotter in the sequential-design collection.

Parameters:
SEQ_LEN, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b0100, pattern bits; PATTERN[SEQ_LEN-1] is the first bit received, PATTERN[0] the last.
OVERLAP, 0, 0 = non-overlapping detection, 1 = overlapping detection.
CNT_W, 8, match counter width; legal range 1..32.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  sample enable; x is consumed only on edges where en=1.
x  input  1  serial data bit.
cnt_clr  input  1  synchronous clear of match_cnt and cnt_sat.
y  output  1  Moore detect flag; 1 exactly while FSM is in the DETECT state.
match_cnt  output  CNT_W  number of DETECT entries since reset or clear; saturating.
cnt_sat  output  1  1 once match_cnt has reached 2^CNT_W-1.

Behaviour:
- State s is the number of pattern bits matched, 0..SEQ_LEN. State SEQ_LEN is DETECT.
- Reset (rst=1 at an edge, overrides all other inputs): s=0, y=0, match_cnt=0, cnt_sat=0. A reset while in DETECT forces y=0 on the following cycle.
- en=0: s, y and the counter hold. cnt_clr is still honoured.
- Transition from s<SEQ_LEN with bit x:
  - If x equals the next expected pattern bit, go to s+1.
  - Otherwise go to the length of the longest prefix of PATTERN that is a proper suffix of (matched prefix followed by x). This is KMP fall-back, not a reset to 0.
- Transition from DETECT with bit x:
  - OVERLAP=0: treat as from state 0.
  - OVERLAP=1: treat as from state b, where b is the longest proper border of PATTERN.
- The transition table is computed at elaboration by a constant function; there is no runtime pattern logic.
- Latency: y=1 in the cycle immediately after the edge that sampled the final pattern bit. It holds while en=0 and DETECT is not left.
- y is registered (a decode of the state register only); it has no combinational path from x.
- Counter:
  - Increments by 1 on each edge where s moves into DETECT, including DETECT-to-DETECT re-entry when OVERLAP=1.
  - Saturates at 2^CNT_W-1; once saturated it does not wrap.
  - cnt_sat is set on the same edge the counter reaches its maximum.
  - If cnt_clr and a DETECT entry occur on the same edge, clear wins: match_cnt=0, cnt_sat=0, and that match is not counted. The FSM still enters DETECT and y asserts.
- Illegal parameters (SEQ_LEN out of range, CNT_W<1) are caught by an elaboration-time $error.

Decomposition:
- Package seq_det_pkg:
  - constant function seq_next(pattern, len, state, bit) returning the next state;
  - constant function seq_border(pattern, len);
  - localparam limits MAX_SEQ_LEN=16 and MAX_CNT_W=32.
- State width is derived locally as $clog2(SEQ_LEN+1).
- One sub-module, sat_counter, parametrised by width. Ports: clk, rst, clr, inc, count, sat. Instantiated for match_cnt.

Test Plan:
1. Defaults (0100, OVERLAP=0), en=1, x stream 0,1,0,0,1,0,0 -> y high for exactly 1 cycle, one cycle after the 4th bit; match_cnt=1 at end.
2. Same stream with OVERLAP=1 -> y pulses after bits 4 and 7 (border=1); match_cnt=2.
3. PATTERN=4'b1111, eight consecutive 1s:
   - OVERLAP=1 -> y high continuously from after bit 4 through after bit 8; match_cnt=5.
   - OVERLAP=0 -> pulses after bits 4 and 8 only; match_cnt=2.
4. Defaults, stream 0,1,0 then en=0 for 5 cycles with x toggling, then en=1 and x=0 -> single detect on the resumed bit; y=0 during the en=0 window.
5. SEQ_LEN=2, PATTERN=2'b11, OVERLAP=1, CNT_W=2, six 1s -> match_cnt counts 1,2,3,3,3; cnt_sat=1 after the 3rd detect; then cnt_clr=1 for one edge -> match_cnt=0, cnt_sat=0.
6. Defaults, rst=1 asserted on the edge after the final 0 of 0100 while y=1 -> y=0 and match_cnt=0 next cycle. Also assert cnt_clr coincident with a detect entry -> y=1 and match_cnt=0.
